glyph_blitter: RTL and testbench

- Parametrised pixel-plotting engine that renders NUM_SLOTS glyph cells (rotor windows, lamps, status letters) into the 160x120 VGA framebuffer through the adapter's x/y/colour/plot port.
- Tracks which slots changed and redraws only those, round-robin, one pixel per accepted cycle.
- Replaces the fixed-count free-running lamp/wheel scanner; supports configurable glyph size, slot count, highlight colour, clipping, forced refresh and plot backpressure.
- Bitmaps come from an external font LUT through a combinational index/bits port.

---
 rtl/glyph_blitter_if.sv | 27 ++
 rtl/glyph_blitter.sv | 180 ++++++++++++++++++
 tb/tb_glyph_blitter.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glyph_blitter_if.sv
// Pixel sink and font LUT bus for glyph_blitter.
// The blitter holds the master side; the VGA adapter and font LUT sit on the slave side.
interface glyph_blitter_if #(
   parameter int IDX_W     = 5,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int COLOUR_W  = 3,
   parameter int FONT_BITS = 25
);
   logic [IDX_W-1:0]     font_idx;
   logic [FONT_BITS-1:0] font_bits;
   logic [X_W-1:0]       x;
   logic [Y_W-1:0]       y;
   logic [COLOUR_W-1:0]  colour;
   logic                 plot;
   logic                 plot_ready;

   modport master (
      output font_idx, x, y, colour, plot,
      input  font_bits, plot_ready
   );

   modport slave (
      input  font_idx, x, y, colour, plot,
      output font_bits, plot_ready
   );
endinterface

// File: rtl/glyph_blitter.sv
// Dirty-tracking glyph renderer: redraws changed slots round-robin, one pixel per
// accepted cycle, with clipping and plot backpressure.
module glyph_blitter #(
   parameter int NUM_SLOTS = 3,
   parameter int GLYPH_W   = 5,
   parameter int GLYPH_H   = 5,
   parameter int IDX_W     = 5,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int COLOUR_W  = 3,
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_SLOTS*IDX_W-1:0]     slot_glyph,
   input  logic [NUM_SLOTS*X_W-1:0]       slot_x,
   input  logic [NUM_SLOTS*Y_W-1:0]       slot_y,
   input  logic [NUM_SLOTS-1:0]           slot_hl,
   input  logic [COLOUR_W-1:0]            fg_colour,
   input  logic [COLOUR_W-1:0]            hl_colour,
   input  logic [COLOUR_W-1:0]            bg_colour,
   input  logic                           force_redraw,
   glyph_blitter_if.master                pix,
   output logic                           busy
);
   localparam int NB = GLYPH_W * GLYPH_H;
   localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
   localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
   localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW} state_e;

   state_e               state_q, state_d;
   logic [SW-1:0]        rr_q, rr_d, sel_q, sel_d;
   logic [NUM_SLOTS-1:0] force_q, force_d, dirty;
   logic [IDX_W-1:0]     cur_glyph [NUM_SLOTS];
   logic [X_W-1:0]       cur_x [NUM_SLOTS];
   logic [Y_W-1:0]       cur_y [NUM_SLOTS];
   logic [IDX_W-1:0]     snap_glyph_q [NUM_SLOTS], snap_glyph_d [NUM_SLOTS];
   logic [X_W-1:0]       snap_x_q [NUM_SLOTS], snap_x_d [NUM_SLOTS];
   logic [Y_W-1:0]       snap_y_q [NUM_SLOTS], snap_y_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] snap_hl_q, snap_hl_d;
   logic [NB-1:0]        bits_q, bits_d;
   logic [X_W-1:0]       wx_q, wx_d;
   logic [Y_W-1:0]       wy_q, wy_d;
   logic                 whl_q, whl_d;
   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic [X_W:0]         px;
   logic [Y_W:0]         py;
   logic                 clip, adv, found;
   logic [SW:0]          cand;

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      assign cur_glyph[g] = slot_glyph[g*IDX_W +: IDX_W];
      assign cur_x[g]     = slot_x[g*X_W +: X_W];
      assign cur_y[g]     = slot_y[g*Y_W +: Y_W];
      assign dirty[g]     = force_q[g] | (cur_glyph[g] != snap_glyph_q[g]) |
                            (cur_x[g] != snap_x_q[g]) | (cur_y[g] != snap_y_q[g]) |
                            (slot_hl[g] != snap_hl_q[g]);
   end

   // Full-width sums so the clip test sees coordinates past the output range.
   always_comb begin
      px   = {1'b0, wx_q} + (X_W+1)'(col_q);
      py   = {1'b0, wy_q} + (Y_W+1)'(row_q);
      clip = (px >= (X_W+1)'(SCREEN_W)) || (py >= (Y_W+1)'(SCREEN_H));
   end

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      sel_d        = sel_q;
      force_d      = force_q;
      snap_glyph_d = snap_glyph_q;
      snap_x_d     = snap_x_q;
      snap_y_d     = snap_y_q;
      snap_hl_d    = snap_hl_q;
      bits_d       = bits_q;
      wx_d         = wx_q;
      wy_d         = wy_q;
      whl_d        = whl_q;
      col_d        = col_q;
      row_d        = row_q;
      adv          = 1'b0;
      found        = 1'b0;
      cand         = '0;
      pix.font_idx = '0;
      pix.x        = '0;
      pix.y        = '0;
      pix.colour   = '0;
      pix.plot     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
               cand = {1'b0, rr_q} + (SW+1)'(k);
               if (cand >= (SW+1)'(NUM_SLOTS)) cand = cand - (SW+1)'(NUM_SLOTS);
               if (!found && dirty[cand[SW-1:0]]) begin
                  found = 1'b1;
                  sel_d = cand[SW-1:0];
               end
            end
            if (found) state_d = S_LOAD;
         end
         S_LOAD: begin
            pix.font_idx        = cur_glyph[sel_q];
            bits_d              = pix.font_bits;
            wx_d                = cur_x[sel_q];
            wy_d                = cur_y[sel_q];
            whl_d               = slot_hl[sel_q];
            snap_glyph_d[sel_q] = cur_glyph[sel_q];
            snap_x_d[sel_q]     = cur_x[sel_q];
            snap_y_d[sel_q]     = cur_y[sel_q];
            snap_hl_d[sel_q]    = slot_hl[sel_q];
            force_d[sel_q]      = 1'b0;
            rr_d                = (sel_q == SW'(NUM_SLOTS-1)) ? '0 : sel_q + 1'b1;
            col_d               = '0;
            row_d               = '0;
            state_d             = S_DRAW;
         end
         S_DRAW: begin
            // Bitmap shifts left per pixel so the current pixel is always the MSB.
            pix.x      = px[X_W-1:0];
            pix.y      = py[Y_W-1:0];
            pix.colour = bits_q[NB-1] ? (whl_q ? hl_colour : fg_colour) : bg_colour;
            pix.plot   = ~clip;
            adv        = clip | pix.plot_ready;
            if (adv) begin
               bits_d = bits_q << 1;
               if (col_q == CW'(GLYPH_W-1)) begin
                  col_d = '0;
                  if (row_q == RW'(GLYPH_H-1)) state_d = S_IDLE;
                  else row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (force_redraw) force_d = '1;
   end

   assign busy = (state_q != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rr_q         <= '0;
         sel_q        <= '0;
         force_q      <= '1;
         snap_glyph_q <= '{default: '0};
         snap_x_q     <= '{default: '0};
         snap_y_q     <= '{default: '0};
         snap_hl_q    <= '0;
         bits_q       <= '0;
         wx_q         <= '0;
         wy_q         <= '0;
         whl_q        <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         sel_q        <= sel_d;
         force_q      <= force_d;
         snap_glyph_q <= snap_glyph_d;
         snap_x_q     <= snap_x_d;
         snap_y_q     <= snap_y_d;
         snap_hl_q    <= snap_hl_d;
         bits_q       <= bits_d;
         wx_q         <= wx_d;
         wy_q         <= wy_d;
         whl_q        <= whl_d;
         col_q        <= col_d;
         row_q        <= row_d;
      end
   end
endmodule

// File: tb/tb_glyph_blitter.sv
// Bench for glyph_blitter: a slot-level reference model predicts the accepted pixel
// stream, which is compared against pixels captured from the plot port.
module tb_glyph_blitter;
   localparam int N  = 3;
   localparam int GW = 5;
   localparam int GH = 5;
   localparam int IW = 5;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CL = 3;
   localparam int NB = GW * GH;

   logic clk = 1'b0;
   logic reset;
   logic force_redraw;
   logic busy;
   logic [CL-1:0] fg, hlc, bg;
   int   g_glyph [N];
   int   g_x [N];
   int   g_y [N];
   bit   g_hl [N];
   logic [N*IW-1:0] slot_glyph;
   logic [N*XW-1:0] slot_x;
   logic [N*YW-1:0] slot_y;
   logic [N-1:0]    slot_hl;

   int vectors = 0;
   int miscompares = 0;

   typedef logic [XW+YW+CL-1:0] pix_t;
   pix_t got[$];
   pix_t exp_q[$];

   logic [XW-1:0] st_x [5];
   logic [YW-1:0] st_y [5];
   logic [CL-1:0] st_c [5];
   logic          st_p [5];

   int m_snap_glyph [N];
   int m_snap_x [N];
   int m_snap_y [N];
   bit m_snap_hl [N];
   bit m_force [N];
   int m_rr;

   always #5 clk = ~clk;

   always_comb begin
      slot_glyph = '0;
      slot_x     = '0;
      slot_y     = '0;
      slot_hl    = '0;
      for (int i = 0; i < N; i++) begin
         slot_glyph[i*IW +: IW] = IW'(g_glyph[i]);
         slot_x[i*XW +: XW]     = XW'(g_x[i]);
         slot_y[i*YW +: YW]     = YW'(g_y[i]);
         slot_hl[i]             = g_hl[i];
      end
   end

   glyph_blitter_if #(.IDX_W(IW), .X_W(XW), .Y_W(YW), .COLOUR_W(CL), .FONT_BITS(NB)) pix ();

   glyph_blitter #(
      .NUM_SLOTS(N), .GLYPH_W(GW), .GLYPH_H(GH), .IDX_W(IW), .X_W(XW), .Y_W(YW),
      .COLOUR_W(CL), .SCREEN_W(160), .SCREEN_H(120)
   ) dut (
      .clk(clk), .reset(reset), .slot_glyph(slot_glyph), .slot_x(slot_x),
      .slot_y(slot_y), .slot_hl(slot_hl), .fg_colour(fg), .hl_colour(hlc),
      .bg_colour(bg), .force_redraw(force_redraw), .pix(pix), .busy(busy)
   );

   function automatic logic [NB-1:0] font_of(input logic [IW-1:0] idx);
      logic [31:0] h;
      case (idx)
         5'd0:    return 25'b00100_01010_11111_10001_10001;
         5'd1:    return 25'b11110_10001_11110_10001_11110;
         5'd2:    return 25'b01111_10000_10000_10000_01111;
         default: begin
            h = {27'd0, idx} * 32'h9E3779B1;
            return h[31:7];
         end
      endcase
   endfunction

   always_comb pix.font_bits = font_of(pix.font_idx);

   always @(negedge clk)
      if (!reset && pix.plot && pix.plot_ready) got.push_back({pix.x, pix.y, pix.colour});

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_snap_glyph[i] = 0; m_snap_x[i] = 0; m_snap_y[i] = 0;
         m_snap_hl[i] = 0; m_force[i] = 1;
      end
      m_rr = 0;
   endfunction

   function automatic bit m_dirty(input int j);
      return m_force[j] || (g_glyph[j] != m_snap_glyph[j]) || (g_x[j] != m_snap_x[j]) ||
             (g_y[j] != m_snap_y[j]) || (g_hl[j] != m_snap_hl[j]);
   endfunction

   function automatic void model_draw(input int j);
      logic [NB-1:0] b;
      logic [CL-1:0] c;
      int px, py;
      b = font_of(IW'(g_glyph[j]));
      for (int r = 0; r < GH; r++)
         for (int k = 0; k < GW; k++) begin
            px = g_x[j] + k;
            py = g_y[j] + r;
            c  = b[NB-1-(r*GW+k)] ? (g_hl[j] ? hlc : fg) : bg;
            if (px < 160 && py < 120) exp_q.push_back({XW'(px), YW'(py), c});
         end
      m_snap_glyph[j] = g_glyph[j]; m_snap_x[j] = g_x[j]; m_snap_y[j] = g_y[j];
      m_snap_hl[j] = g_hl[j]; m_force[j] = 0;
      m_rr = (j + 1) % N;
   endfunction

   // Redraws every dirty slot in round-robin order, assuming inputs stay put meanwhile.
   function automatic void model_run();
      int j;
      bit hit;
      for (int it = 0; it < N; it++) begin
         hit = 0;
         for (int k = 0; k < N && !hit; k++) begin
            j = (m_rr + k) % N;
            if (m_dirty(j)) hit = 1;
         end
         if (!hit) break;
         model_draw(j);
      end
   endfunction

   task automatic drain(input int stall_at, input int stall_len, input bit rnd,
                        output int busy_cyc, output bit tmo);
      int idle_run, acc, cyc, s;
      bit stalled;
      idle_run = 0; acc = 0; cyc = 0; s = 0; stalled = 0; busy_cyc = 0; tmo = 0;
      while (1) begin
         @(posedge clk); #1;
         cyc++;
         if (s > 0) begin
            st_x[stall_len-s] = pix.x; st_y[stall_len-s] = pix.y;
            st_c[stall_len-s] = pix.colour; st_p[stall_len-s] = pix.plot;
            s--;
            if (s == 0) pix.plot_ready = 1'b1;
         end else if (!stalled && stall_at >= 0 && pix.plot && acc == stall_at) begin
            pix.plot_ready = 1'b0; s = stall_len; stalled = 1;
         end else if (rnd) begin
            pix.plot_ready = ($urandom_range(0, 3) != 0);
         end
         if (pix.plot && pix.plot_ready) acc++;
         if (busy) begin busy_cyc++; idle_run = 0; end
         else idle_run++;
         if (idle_run >= 3) break;
         if (cyc >= 3000) begin tmo = 1; break; end
      end
      pix.plot_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1; force_redraw = 0; pix.plot_ready = 1;
      fg = 3'b011; hlc = 3'b110; bg = 3'b000;
      g_glyph[0] = 0; g_x[0] = 56; g_y[0] = 82; g_hl[0] = 0;
      g_glyph[1] = 1; g_x[1] = 77; g_y[1] = 82; g_hl[1] = 0;
      g_glyph[2] = 2; g_x[2] = 99; g_y[2] = 82; g_hl[2] = 0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (pix.plot !== 1'b0) begin miscompares++; $display("FAIL reset_plot: got %b want 0", pix.plot); end
      vectors++; if (pix.x !== '0) begin miscompares++; $display("FAIL reset_x: got %0d want 0", pix.x); end
      vectors++; if (pix.y !== '0) begin miscompares++; $display("FAIL reset_y: got %0d want 0", pix.y); end
      vectors++; if (pix.colour !== '0) begin miscompares++; $display("FAIL reset_colour: got %0d want 0", pix.colour); end
      vectors++; if (pix.font_idx !== '0) begin miscompares++; $display("FAIL reset_font_idx: got %0d want 0", pix.font_idx); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_first_frame();
      int bc; bit tmo;
      logic [CL-1:0] row0 [5];
      row0 = '{bg, bg, fg, bg, bg};
      got.delete(); exp_q.delete();
      reset = 0;
      model_reset(); model_run();
      drain(-1, 0, 0, bc, tmo);
      vectors++; if (tmo) begin miscompares++; $display("FAIL frame_timeout: busy never settled"); end
      vectors++; if (bc != 78) begin miscompares++; $display("FAIL frame_busy_cycles: got %0d want 78", bc); end
      vectors++; if (got.size() != 75) begin miscompares++; $display("FAIL frame_count: got %0d want 75", got.size()); end
      if (got.size() >= 5) begin
         vectors++;
         if (got[0][17:10] !== 8'd56 || got[0][9:3] !== 7'd82) begin
            miscompares++; $display("FAIL frame_first_pixel: got (%0d,%0d) want (56,82)", got[0][17:10], got[0][9:3]);
         end
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (got[i][2:0] !== row0[i]) begin
               miscompares++; $display("FAIL frame_A_row0[%0d]: got %b want %b", i, got[i][2:0], row0[i]);
            end
         end
      end
      vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL frame_size: got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL frame_pixel[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", i,
                     got[i][17:10], got[i][9:3], got[i][2:0], exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
         end
      end
      vectors++; if (pix.plot !== 1'b0) begin miscompares++; $display("FAIL frame_plot_after: got %b want 0", pix.plot); end
   endtask

   task automatic test_idle_quiet();
      int bad = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (pix.plot !== 1'b0 || busy !== 1'b0) bad++;
      end
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL idle_quiet: %0d active cycles, want 0", bad); end
   endtask

   task automatic test_highlight();
      int bc, bad; bit tmo;
      got.delete(); exp_q.delete();
      g_hl[1] = 1;
      model_run();
      drain(-1, 0, 0, bc, tmo);
      vectors++; if (tmo) begin miscompares++; $display("FAIL hl_timeout: busy never settled"); end
      vectors++; if (got.size() != 25) begin miscompares++; $display("FAIL hl_count: got %0d want 25", got.size()); end
      bad = 0;
      foreach (got[i]) if (got[i][2:0] !== 3'b110 && got[i][2:0] !== 3'b000) bad++;
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL hl_colours: %0d pixels neither 110 nor 000", bad); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL hl_pixel[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", i,
                     got[i][17:10], got[i][9:3], got[i][2:0], exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int bc; bit tmo;
      got.delete(); exp_q.delete();
      g_glyph[0] = 3;
      model_run();
      drain(7, 5, 0, bc, tmo);
      vectors++; if (tmo) begin miscompares++; $display("FAIL bp_timeout: busy never settled"); end
      vectors++; if (bc != 31) begin miscompares++; $display("FAIL bp_busy_cycles: got %0d want 31", bc); end
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (st_x[k] !== 8'd58 || st_y[k] !== 7'd83 || st_p[k] !== 1'b1 || st_c[k] !== exp_q[7][2:0]) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got x=%0d y=%0d c=%0d plot=%b want x=58 y=83 c=%0d plot=1",
                     k, st_x[k], st_y[k], st_c[k], st_p[k], exp_q[7][2:0]);
         end
      end
      vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_size: got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL bp_pixel[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", i,
                     got[i][17:10], got[i][9:3], got[i][2:0], exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
         end
      end
   endtask

   task automatic test_clip();
      int bc, at_edge; bit tmo;
      got.delete(); exp_q.delete();
      g_x[2] = 158;
      model_run();
      drain(-1, 0, 0, bc, tmo);
      vectors++; if (tmo) begin miscompares++; $display("FAIL clip_timeout: busy never settled"); end
      vectors++; if (bc != 26) begin miscompares++; $display("FAIL clip_busy_cycles: got %0d want 26", bc); end
      vectors++; if (got.size() != 10) begin miscompares++; $display("FAIL clip_count: got %0d want 10", got.size()); end
      at_edge = 0;
      foreach (got[i]) if (got[i][17:10] >= 8'd160) at_edge++;
      vectors++; if (at_edge != 0) begin miscompares++; $display("FAIL clip_offscreen: %0d plotted pixels at x>=160, want 0", at_edge); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL clip_pixel[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", i,
                     got[i][17:10], got[i][9:3], got[i][2:0], exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
         end
      end
   endtask

   task automatic test_random();
      int bc; bit tmo;
      for (int round = 0; round < 8; round++) begin
         got.delete(); exp_q.delete();
         for (int j = 0; j < N; j++)
            if ($urandom_range(0, 1) == 1) begin
               g_glyph[j] = $urandom_range(0, 25);
               g_x[j] = $urandom_range(0, 165);
               g_y[j] = $urandom_range(0, 122);
               g_hl[j] = $urandom_range(0, 1);
            end
         fg = CL'($urandom_range(0, 7)); hlc = CL'($urandom_range(0, 7)); bg = CL'($urandom_range(0, 7));
         model_run();
         drain(-1, 0, 1, bc, tmo);
         vectors++; if (tmo) begin miscompares++; $display("FAIL rand_timeout[%0d]: busy never settled", round); end
         vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_size[%0d]: got %0d want %0d", round, got.size(), exp_q.size()); end
         for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL rand_pixel[%0d][%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", round, i,
                        got[i][17:10], got[i][9:3], got[i][2:0], exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
            end
         end
      end
   endtask

   task automatic test_force_reset();
      int bc, acc, cyc; bit tmo, seen;
      fg = 3'b011; hlc = 3'b110; bg = 3'b000;
      g_glyph[1] = 1; g_x[1] = 77; g_y[1] = 82; g_hl[1] = !g_hl[1];
      seen = 0;
      for (cyc = 0; cyc < 50 && !seen; cyc++) begin
         @(posedge clk); #1;
         if (busy) seen = 1;
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL force_load_seen: busy=0 want 1 within 50 cycles"); end
      vectors++; if (pix.font_idx !== 5'd1) begin miscompares++; $display("FAIL force_load_font_idx: got %0d want 1", pix.font_idx); end
      force_redraw = 1;
      @(posedge clk); #1;
      force_redraw = 0;
      acc = 0;
      for (cyc = 0; cyc < 100 && !(pix.plot && acc == 12); cyc++) begin
         if (pix.plot) acc++;
         @(posedge clk); #1;
      end
      vectors++; if (acc != 12) begin miscompares++; $display("FAIL force_reach_px12: got %0d pixels want 12", acc); end
      reset = 1;
      @(posedge clk); #1;
      got.delete(); exp_q.delete();
      vectors++; if (pix.plot !== 1'b0) begin miscompares++; $display("FAIL midreset_plot: got %b want 0", pix.plot); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      reset = 0;
      model_reset(); model_run();
      drain(-1, 0, 0, bc, tmo);
      vectors++; if (tmo) begin miscompares++; $display("FAIL post_reset_timeout: busy never settled"); end
      vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL post_reset_size: got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL post_reset_pixel[%0d]: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", i,
                     got[i][17:10], got[i][9:3], got[i][2:0], exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_idle_quiet();
      test_highlight();
      test_backpressure();
      test_clip();
      test_random();
      test_force_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
